// File: rtl/inst_encoder.sv
// Two-wide RV32I encoder: turns decode_struct micro-ops back into instruction
// words and packs them into {older, younger} issue bundles. Optional macro: INST_ENC_PAD_TIMEOUT_EN.

package inst_encoder_pkg;
   typedef logic [31:0] word;

   typedef struct packed {
      logic [4:0]  ARegAddrSrc0;
      logic [4:0]  ARegAddrSrc1;
      logic [4:0]  ARegAddrDst;
      logic [31:0] immediate;
      logic [2:0]  ALUOp;
      logic        ALUSrc;
      logic        RegWrite;
      logic        MemRead;
      logic        MemWrite;
   } decode_struct;

   typedef enum logic {
      EMPTY = 1'b0,
      HALF  = 1'b1
   } pack_state_e;
endpackage

module inst_encoder
   import inst_encoder_pkg::*;
#(
   parameter int unsigned PAD_TIMEOUT = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  decode_struct       i_uop,
   input  logic               i_uop_valid,
   output logic               o_uop_ready,
   input  logic               i_flush,
   output word [0:1]          o_insts,
   output logic               o_insts_valid,
   input  logic               i_insts_ready,
   output logic               o_illegal,
   output pack_state_e        o_pack_state
);

   localparam word NOP = '0;

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // the producer holds valid and data stable until that edge.

   logic [11:0] imm;
   logic [4:0]  rs1, rs2, rd;
   word         enc_word;
   logic        enc_illegal;

   assign imm = i_uop.immediate[11:0];
   assign rs1 = i_uop.ARegAddrSrc0;
   assign rs2 = i_uop.ARegAddrSrc1;
   assign rd  = i_uop.ARegAddrDst;

   always_comb begin
      enc_word    = NOP;
      enc_illegal = 1'b0;
      if (i_uop.MemWrite) begin
         enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      end else if (i_uop.MemRead) begin
         enc_word = {imm, rs1, 3'b010, rd, 7'b0000011};
      end else if (i_uop.RegWrite && i_uop.ALUSrc) begin
         case (i_uop.ALUOp)
            3'b001:  enc_word = {imm, rs1, 3'b000, rd, 7'b0010011};
            3'b100:  enc_word = {imm, rs1, 3'b111, rd, 7'b0010011};
            default: enc_illegal = 1'b1;
         endcase
      end else if (i_uop.RegWrite) begin
         case (i_uop.ALUOp)
            3'b001:  enc_word = {7'h00, rs2, rs1, 3'b000, rd, 7'b0110011};
            3'b010:  enc_word = {7'h20, rs2, rs1, 3'b000, rd, 7'b0110011};
            3'b011:  enc_word = {7'h00, rs2, rs1, 3'b100, rd, 7'b0110011};
            3'b101:  enc_word = {7'h20, rs2, rs1, 3'b101, rd, 7'b0110011};
            default: enc_illegal = 1'b1;
         endcase
      end else if (i_uop.ALUOp != 3'b000 || i_uop.ALUSrc) begin
         enc_illegal = 1'b1;
      end
   end

   pack_state_e state_q, state_d;
   word         pend_q;
   logic        flush_pend_q, flush_pend_d;
   word [0:1]   out_q;
   logic        out_valid_q;
   logic        illegal_q;
   logic        out_free, accept, pad_req, timeout_hit;
   logic        emit, pend_load;
   word [0:1]   emit_bundle;

   assign out_free = !out_valid_q || i_insts_ready;
   assign accept   = i_uop_valid && o_uop_ready;
   // A flush or timeout that hits a full output is remembered until it can drain.
   assign pad_req  = i_flush || flush_pend_q || timeout_hit;

`ifdef INST_ENC_PAD_TIMEOUT_EN
   localparam logic [7:0] PAD_TO = 8'(PAD_TIMEOUT);
   logic [7:0] pad_cnt_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pad_cnt_q <= '0;
      end else if (state_q != HALF || accept || state_d != HALF) begin
         pad_cnt_q <= '0;
      end else if (pad_cnt_q != PAD_TO) begin
         pad_cnt_q <= pad_cnt_q + 8'd1;
      end
   end

   assign timeout_hit = (state_q == HALF) && (pad_cnt_q == PAD_TO);
`else
   logic unused_pad_cfg;
   assign unused_pad_cfg = ^8'(PAD_TIMEOUT);
   assign timeout_hit    = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= EMPTY;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      flush_pend_d = flush_pend_q;
      emit         = 1'b0;
      pend_load    = 1'b0;
      emit_bundle  = {pend_q, enc_word};
      case (state_q)
         EMPTY: begin
            if (accept) begin
               if (i_flush && out_free) begin
                  emit        = 1'b1;
                  emit_bundle = {enc_word, NOP};
               end else begin
                  state_d      = HALF;
                  pend_load    = 1'b1;
                  flush_pend_d = i_flush;
               end
            end
         end
         HALF: begin
            if (accept) begin
               emit         = 1'b1;
               emit_bundle  = {pend_q, enc_word};
               state_d      = EMPTY;
               flush_pend_d = 1'b0;
            end else if (pad_req) begin
               if (out_free) begin
                  emit         = 1'b1;
                  emit_bundle  = {pend_q, NOP};
                  state_d      = EMPTY;
                  flush_pend_d = 1'b0;
               end else begin
                  flush_pend_d = 1'b1;
               end
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      o_uop_ready   = (state_q != HALF) || out_free;
      o_pack_state  = state_q;
      o_insts       = out_q;
      o_insts_valid = out_valid_q;
      o_illegal     = illegal_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pend_q       <= NOP;
         flush_pend_q <= 1'b0;
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         illegal_q    <= 1'b0;
      end else begin
         flush_pend_q <= flush_pend_d;
         if (pend_load) pend_q <= enc_word;
         if (emit) begin
            out_q       <= emit_bundle;
            out_valid_q <= 1'b1;
         end else if (i_insts_ready) begin
            out_valid_q <= 1'b0;
         end
         if (accept && enc_illegal) illegal_q <= 1'b1;
      end
   end

   logic unused_imm;
   assign unused_imm = ^i_uop.immediate[31:12];

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed encode/pack scenarios plus a
// short random legal stream, checked through an expected-bundle queue.
module tb_inst_encoder;
   import inst_encoder_pkg::*;

   localparam int PAD_TO = 8;

   logic         i_clk;
   logic         i_rst_n;
   decode_struct i_uop;
   logic         i_uop_valid;
   logic         o_uop_ready;
   logic         i_flush;
   word [0:1]    o_insts;
   logic         o_insts_valid;
   logic         i_insts_ready;
   logic         o_illegal;
   pack_state_e  o_pack_state;

   inst_encoder #(.PAD_TIMEOUT(PAD_TO)) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_uop         (i_uop),
      .i_uop_valid   (i_uop_valid),
      .o_uop_ready   (o_uop_ready),
      .i_flush       (i_flush),
      .o_insts       (o_insts),
      .o_insts_valid (o_insts_valid),
      .i_insts_ready (i_insts_ready),
      .o_illegal     (o_illegal),
      .o_pack_state  (o_pack_state)
   );

   // clock / reset
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int n_checks = 0;
   int n_fail   = 0;
   logic [63:0] exp_q[$];
   logic        pend_v;
   word         pend_w;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // reference encoders
   function automatic word enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                 input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic word enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                 input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic word enc_s(input logic [11:0] imm, input logic [4:0] rs2, rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
   endfunction

   function automatic decode_struct mk_uop(input logic [4:0] s0, s1, d, input logic [11:0] imm,
                                           input logic [2:0] op, input logic alusrc, rw, mr, mw);
      decode_struct u;
      u = '0;
      u.ARegAddrSrc0 = s0;
      u.ARegAddrSrc1 = s1;
      u.ARegAddrDst  = d;
      u.immediate    = {{20{imm[11]}}, imm};
      u.ALUOp        = op;
      u.ALUSrc       = alusrc;
      u.RegWrite     = rw;
      u.MemRead      = mr;
      u.MemWrite     = mw;
      return u;
   endfunction

   task automatic rand_legal(output decode_struct u, output word w);
      logic [4:0]  a, b, d;
      logic [11:0] imm;
      int          k;
      a   = 5'($urandom_range(0, 31));
      b   = 5'($urandom_range(0, 31));
      d   = 5'($urandom_range(0, 31));
      imm = 12'($urandom_range(0, 4095));
      k   = $urandom_range(0, 7);
      case (k)
         0: begin u = mk_uop(a, b, d, imm, 3'b001, 0, 1, 0, 0); w = enc_r(7'h00, b, a, 3'd0, d); end
         1: begin u = mk_uop(a, b, d, imm, 3'b010, 0, 1, 0, 0); w = enc_r(7'h20, b, a, 3'd0, d); end
         2: begin u = mk_uop(a, b, d, imm, 3'b011, 0, 1, 0, 0); w = enc_r(7'h00, b, a, 3'd4, d); end
         3: begin u = mk_uop(a, b, d, imm, 3'b101, 0, 1, 0, 0); w = enc_r(7'h20, b, a, 3'd5, d); end
         4: begin u = mk_uop(a, b, d, imm, 3'b001, 1, 1, 0, 0); w = enc_i(imm, a, 3'd0, d, 7'h13); end
         5: begin u = mk_uop(a, b, d, imm, 3'b100, 1, 1, 0, 0); w = enc_i(imm, a, 3'd7, d, 7'h13); end
         6: begin
            u = mk_uop(a, b, d, imm, 3'($urandom_range(0, 7)), 1, 1, 1, 0);
            w = enc_i(imm, a, 3'd2, d, 7'h03);
         end
         default: begin
            u = mk_uop(a, b, d, imm, 3'b001, 1, 0, 1'($urandom_range(0, 1)), 1);
            w = enc_s(imm, b, a);
         end
      endcase
   endtask

   // driver tasks (inputs change 1 time unit after the rising edge)
   task automatic drive_uop(input decode_struct u, input word w, input logic flush);
      logic acc;
      acc         = 1'b0;
      i_uop       = u;
      i_uop_valid = 1'b1;
      i_flush     = flush;
      for (int n = 0; n < 100 && !acc; n++) begin
         @(negedge i_clk);
         acc = o_uop_ready;
         @(posedge i_clk);
         #1;
      end
      i_uop_valid = 1'b0;
      i_flush     = 1'b0;
      check("accept_bound", acc, 1'b1);
      if (acc) begin
         if (pend_v) begin
            exp_q.push_back({pend_w, w});
            pend_v = 1'b0;
         end else if (flush) begin
            exp_q.push_back({w, 32'h0});
         end else begin
            pend_v = 1'b1;
            pend_w = w;
         end
      end
   endtask

   task automatic do_flush();
      i_flush = 1'b1;
      @(posedge i_clk);
      #1;
      i_flush = 1'b0;
      if (pend_v) begin
         exp_q.push_back({pend_w, 32'h0});
         pend_v = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic drain();
      for (int n = 0; n < 50 && (exp_q.size() != 0 || o_insts_valid); n++) idle(1);
      check("drain_bound", exp_q.size(), 0);
   endtask

   // scoreboard monitor: a bundle transfers on an edge with valid && ready
   always @(negedge i_clk) begin
      if (i_rst_n && o_insts_valid && i_insts_ready) begin
         check("sb_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) check("sb_bundle", o_insts, exp_q.pop_front());
      end
   end

   decode_struct u_add, u_sub, u_addi, u_lw, u_sw, u_bad, ur;
   word          wr;

   initial begin
      i_rst_n       = 1'b0;
      i_uop         = '0;
      i_uop_valid   = 1'b0;
      i_flush       = 1'b0;
      i_insts_ready = 1'b1;
      pend_v        = 1'b0;
      pend_w        = '0;

      u_add  = mk_uop(5'd1, 5'd2, 5'd3, 12'd0, 3'b001, 0, 1, 0, 0);
      u_sub  = mk_uop(5'd6, 5'd7, 5'd5, 12'd0, 3'b010, 0, 1, 0, 0);
      u_addi = mk_uop(5'd0, 5'd0, 5'd1, 12'd5, 3'b001, 1, 1, 0, 0);
      u_lw   = mk_uop(5'd2, 5'd0, 5'd4, 12'd8, 3'b001, 1, 1, 1, 0);
      u_sw   = mk_uop(5'd2, 5'd5, 5'd0, 12'd12, 3'b001, 1, 0, 0, 1);
      u_bad  = mk_uop(5'd1, 5'd2, 5'd3, 12'd0, 3'b100, 0, 1, 0, 0);

      // reset values
      idle(3);
      check("rst_valid", o_insts_valid, 1'b0);
      check("rst_insts", o_insts, 64'h0);
      check("rst_illegal", o_illegal, 1'b0);
      check("rst_ready", o_uop_ready, 1'b1);
      check("rst_state", o_pack_state, EMPTY);
      i_rst_n = 1'b1;
      idle(1);

      // ADD + SUB back to back: bundle valid the cycle after the second accept
      drive_uop(u_add, 32'h002081B3, 1'b0);
      check("half_state", o_pack_state, HALF);
      check("half_no_out", o_insts_valid, 1'b0);
      drive_uop(u_sub, 32'h407302B3, 1'b0);
      check("pair_valid", o_insts_valid, 1'b1);
      check("pair_insts", o_insts, {32'h002081B3, 32'h407302B3});
      drain();

      // ADDI then flush next cycle
      drive_uop(u_addi, 32'h00500093, 1'b0);
      do_flush();
      check("flush_insts", o_insts, {32'h00500093, 32'h0});
      check("flush_state", o_pack_state, EMPTY);
      drain();

`ifdef INST_ENC_PAD_TIMEOUT_EN
      // lone word padded after the timeout
      begin
         int n;
         drive_uop(u_addi, 32'h00500093, 1'b0);
         exp_q.push_back({32'h00500093, 32'h0});
         pend_v = 1'b0;
         n = 0;
         while (!o_insts_valid && n < 40) begin
            idle(1);
            n++;
         end
         check("timeout_cycles", n, PAD_TO + 1);
         check("timeout_insts", o_insts, {32'h00500093, 32'h0});
         drain();
      end
`else
      // lone word waits indefinitely without the timeout
      drive_uop(u_addi, 32'h00500093, 1'b0);
      idle(20);
      check("lone_wait_valid", o_insts_valid, 1'b0);
      check("lone_wait_state", o_pack_state, HALF);
      do_flush();
      drain();
`endif

      // LW + SW held under back-pressure; third uop makes HALF and drops ready
      i_insts_ready = 1'b0;
      drive_uop(u_lw, 32'h00812203, 1'b0);
      drive_uop(u_sw, 32'h00512623, 1'b0);
      drive_uop(u_lw, 32'h00812203, 1'b0);
      @(negedge i_clk);
      check("bp_uop_ready", o_uop_ready, 1'b0);
      @(posedge i_clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_valid", o_insts_valid, 1'b1);
         check("bp_hold_insts", o_insts, {32'h00812203, 32'h00512623});
         idle(1);
      end
      i_insts_ready = 1'b1;
      do_flush();
      drain();

      // flush blocked by a full output drains once it frees
      i_insts_ready = 1'b0;
      drive_uop(u_add, 32'h002081B3, 1'b0);
      drive_uop(u_sub, 32'h407302B3, 1'b0);
      drive_uop(u_addi, 32'h00500093, 1'b0);
      do_flush();
      idle(3);
      check("blk_flush_state", o_pack_state, HALF);
      i_insts_ready = 1'b1;
      drain();
      check("blk_flush_done", o_pack_state, EMPTY);

      // flush with EMPTY and no accept: nothing happens
      do_flush();
      idle(1);
      check("empty_flush_valid", o_insts_valid, 1'b0);

      // flush with accept: EMPTY pads, HALF pairs
      drive_uop(u_sub, 32'h407302B3, 1'b1);
      check("empty_acc_flush", o_insts, {32'h407302B3, 32'h0});
      drain();
      drive_uop(u_add, 32'h002081B3, 1'b0);
      drive_uop(u_lw, 32'h00812203, 1'b1);
      check("half_acc_flush", o_insts, {32'h002081B3, 32'h00812203});
      drain();

      // illegal micro-op: word 0, sticky flag
      check("pre_illegal", o_illegal, 1'b0);
      drive_uop(u_bad, 32'h0, 1'b0);
      check("illegal_set", o_illegal, 1'b1);
      for (int i = 0; i < 10; i++) begin
         rand_legal(ur, wr);
         drive_uop(ur, wr, 1'b0);
         check("illegal_sticky", o_illegal, 1'b1);
      end
      if (pend_v) do_flush();
      drain();

      // random legal stream
      for (int i = 0; i < 40; i++) begin
         rand_legal(ur, wr);
         drive_uop(ur, wr, 1'($urandom_range(0, 3) == 0));
      end
      if (pend_v) do_flush();
      drain();

      // reset mid-operation: bundle valid and a word pending
      i_insts_ready = 1'b0;
      drive_uop(u_add, 32'h002081B3, 1'b0);
      drive_uop(u_sub, 32'h407302B3, 1'b0);
      drive_uop(u_lw, 32'h00812203, 1'b0);
      i_rst_n = 1'b0;
      #1;
      check("mid_rst_valid", o_insts_valid, 1'b0);
      check("mid_rst_insts", o_insts, 64'h0);
      check("mid_rst_illegal", o_illegal, 1'b0);
      check("mid_rst_ready", o_uop_ready, 1'b1);
      check("mid_rst_state", o_pack_state, EMPTY);
      exp_q.delete();
      pend_v = 1'b0;
      i_insts_ready = 1'b1;
      idle(2);
      i_rst_n = 1'b1;
      do_flush();
      idle(3);
      check("post_rst_quiet", o_insts_valid, 1'b0);
      drive_uop(u_sw, 32'h00512623, 1'b1);
      check("post_rst_insts", o_insts, {32'h00512623, 32'h0});
      drain();

      check("final_pending", pend_v, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
